// File: rtl/fifo_pick_cnt.sv
// First-word-fall-through FIFO with occupancy count, almost-full/empty thresholds,
// synchronous clear and sticky overflow/underflow flags. Any DEPTH >= 2 is supported.
module fifo_pick_cnt #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic                       ck,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       write,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       read,
  output logic [WIDTH-1:0]           dataout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);
  localparam logic [CW-1:0] ONE_LVL  = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a write when the head is being popped on the same edge.
  assign wr_ok      = write & (~full | read);
  assign rd_ok      = read & ~empty;
  assign rd_ptr_nxt = next_ptr(rd_ptr);

  assign full         = (count == FULL_LVL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // NOTE: storage has no reset; every entry is written before it can reach dataout,
  // so resetting it would only cost flops and reset fan-out.
  always_ff @(posedge ck) begin
    if (!reset && !clear && wr_ok)
      mem[wr_ptr] <= datain;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values (count, rd_ptr, full) regardless of statement order.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dataout   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= rd_ptr_nxt;

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Head register: load on fill-from-empty, advance on pop, bypass when the
      // last word is popped while a new one arrives; otherwise hold.
      if (empty && wr_ok)
        dataout <= datain;
      else if (rd_ok && count > ONE_LVL)
        dataout <= mem[rd_ptr_nxt];
      else if (rd_ok && wr_ok)
        dataout <= datain;

      if (write && full && !read) overflow  <= 1'b1;
      if (read && empty)          underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pick_cnt.sv
// Directed bench for fifo_pick_cnt (DEPTH=5): the driver queues expected head words,
// a negedge monitor pops and compares them whenever a word is consumed.
module tb_fifo_pick_cnt;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             ck = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             write = 1'b0;
  logic [WIDTH-1:0] datain = '0;
  logic             read = 1'b0;
  logic [WIDTH-1:0] dataout;
  logic             full, empty, almost_full, almost_empty;
  logic [CW-1:0]    count;
  logic             overflow, underflow;

  int n_checks = 0;
  int n_fails  = 0;
  logic [WIDTH-1:0] exp_q [$];

  fifo_pick_cnt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
    .ck(ck), .reset(reset), .clear(clear), .write(write), .datain(datain),
    .read(read), .dataout(dataout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 ck = ~ck;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply one cycle of stimulus; 'push' says whether the write must be accepted.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r,
                     input logic c, input logic push);
    write  = w;
    datain = d;
    read   = r;
    clear  = c;
    if (c) exp_q.delete();
    if (push) exp_q.push_back(d);
    @(posedge ck);
    #1;
    write = 1'b0;
    read  = 1'b0;
    clear = 1'b0;
  endtask

  // Monitor: a word is consumed whenever read is high on a non-empty FIFO.
  always @(negedge ck) begin
    if (!reset && read && !empty) begin
      if (exp_q.size() == 0)
        check("pop_without_expected", 32'(dataout), 32'hFFFF_FFFF);
      else
        check("dataout_seq", 32'(dataout), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(posedge ck); #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_dataout", dataout, 0);
    check("rst_ovf_udf", {overflow, underflow}, 0);
    #3 reset = 1'b0;
    @(posedge ck); #1;

    // FWFT latency and count
    cyc(1, 8'h11, 0, 0, 1);
    check("fwft_empty", empty, 0);
    check("fwft_dataout", dataout, 8'h11);
    check("ae_at_1", almost_empty, 1);
    cyc(1, 8'h22, 0, 0, 1);
    cyc(1, 8'h33, 0, 0, 1);
    check("count_3", count, 3);
    check("ae_at_3", almost_empty, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0);
    check("drain3_empty", empty, 1);

    // Fill to full, overflow, drain
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'hA0 + 8'(i), 0, 0, 1);
      if (i == 3) check("af_at_4", {almost_full, full}, 2'b10);
    end
    check("full_flag", full, 1);
    check("full_count", count, 5);
    check("full_af", almost_full, 1);
    cyc(1, 8'hFF, 0, 0, 0);
    check("ovf_count", count, 5);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0);
    check("drain5_empty", empty, 1);
    check("hold_last_dataout", dataout, 8'hA4);
    check("ovf_sticky", overflow, 1);

    // Clear, then simultaneous read+write on a full FIFO across pointer wrap
    cyc(0, 8'h00, 0, 1, 0);
    check("clear_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'hB0 + 8'(i), 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 8'h50 + 8'(i), 1, 0, 1);
      check("rw_full_count", count, 5);
    end
    check("rw_full_no_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0);
    check("wrap_drain_empty", empty, 1);

    // Bypass with count==1
    cyc(1, 8'h77, 0, 0, 1);
    check("head_77", dataout, 8'h77);
    cyc(1, 8'h88, 1, 0, 1);
    check("bypass_dataout", dataout, 8'h88);
    check("bypass_count", count, 1);
    check("bypass_empty", empty, 0);
    cyc(0, 8'h00, 1, 0, 0);

    // Underflow, then clear overriding a write
    for (int i = 0; i < 5; i++) cyc(1, 8'hC0 + 8'(i), 0, 0, 1);
    cyc(1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    check("udf_flag", underflow, 1);
    check("udf_count", count, 0);
    cyc(1, 8'h99, 0, 1, 0);
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_flags", {overflow, underflow}, 0);
    check("clr_dataout_hold", dataout, 8'hC4);

    // Async reset mid-burst
    cyc(1, 8'h01, 0, 0, 1);
    cyc(1, 8'h02, 0, 0, 1);
    cyc(1, 8'h03, 0, 0, 1);
    check("pre_rst_count", count, 3);
    write  = 1'b1;
    datain = 8'h44;
    #2 reset = 1'b1;
    #1;
    check("async_rst_empty", empty, 1);
    check("async_rst_count", count, 0);
    check("async_rst_dataout", dataout, 0);
    exp_q.delete();
    write = 1'b0;
    #2 reset = 1'b0;
    @(posedge ck); #1;
    check("post_rst_count", count, 0);
    cyc(1, 8'h3C, 0, 0, 1);
    check("post_rst_empty", empty, 0);
    check("post_rst_dataout", dataout, 8'h3C);
    cyc(0, 8'h00, 1, 0, 0);

    repeat (2) @(posedge ck);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
